// File: rtl/seg_ctrl_pkg.sv
// Shared definitions for the seven-segment counter control path.
//   state_t      : key repeat controller state encoding (2-bit)
//   dir_t        : step direction held while a key is down
//   HOLD_0P5S    : 0.5 s at 25 MHz, press-to-first-repeat delay
//   REPEAT_100MS : 100 ms at 25 MHz, auto-repeat spacing
package seg_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_CHORD  = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int HOLD_0P5S    = 12500000;
    localparam int REPEAT_100MS = 2500000;

endpackage

// File: rtl/repeat_timer.sv
// Loadable down-counter with a zero flag.
//   i_Clk, i_Reset : clock, asynchronous active-high reset (count -> 0)
//   i_Load         : load i_Load_Value (takes priority over enable)
//   i_Load_Value   : value to load
//   i_Enable       : decrement by one; holds at zero, never underflows
//   o_Count        : current value
//   o_Zero         : high while the count is zero
module repeat_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Load_Value,
    input  logic             i_Enable,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_Zero
);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Count <= '0;
        end else if (i_Load) begin
            o_Count <= i_Load_Value;
        end else if (i_Enable && (o_Count != '0)) begin
            o_Count <= o_Count - 1'b1;
        end
    end

    assign o_Zero = (o_Count == '0);

endmodule

// File: rtl/key_repeat_counter_ctrl.sv
// Button-driven up/down counter with hold-to-repeat, wrap-around at both
// ends and clear when both keys are held together.
//   i_Clk, i_Reset         : clock, asynchronous active-high reset
//   i_Key_Up, i_Key_Down   : debounced key levels, 1 = pressed
//   o_Count                : current count
//   o_Digit_Hi, o_Digit_Lo : upper / lower halves of o_Count
//   o_Step                 : one-cycle pulse after every count change
//   o_Wrap                 : with o_Step when that step wrapped
//   o_Repeating            : high while auto-repeating
//   o_State                : controller state, for observation
module key_repeat_counter_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int MAX_COUNT     = 255,
    parameter int HOLD_CYCLES   = HOLD_0P5S,
    parameter int REPEAT_CYCLES = REPEAT_100MS
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Key_Up,
    input  logic               i_Key_Down,
    output logic [WIDTH-1:0]   o_Count,
    output logic [WIDTH/2-1:0] o_Digit_Hi,
    output logic [WIDTH/2-1:0] o_Digit_Lo,
    output logic               o_Step,
    output logic               o_Wrap,
    output logic               o_Repeating,
    output logic [1:0]         o_State
);

    localparam int T_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW    = (T_MAX <= 2) ? 1 : $clog2(T_MAX);

    state_t         state, next_state;
    dir_t           dir, next_dir;
    logic [WIDTH-1:0] count, next_count;
    logic           key_up_q, key_down_q;
    logic           rise_up, rise_down;
    logic           step_next, wrap_next;
    logic           timer_load, timer_en, timer_zero;
    logic [TW-1:0]  timer_load_value;
    logic [TW-1:0]  timer_count;
    logic [WIDTH-1:0] up_val, down_val, dir_val;
    logic           up_wrap, down_wrap, dir_wrap;
    logic           active_key, other_key;

    assign rise_up   = i_Key_Up & ~key_up_q;
    assign rise_down = i_Key_Down & ~key_down_q;

    assign up_wrap   = (count == WIDTH'(MAX_COUNT));
    assign up_val    = up_wrap ? '0 : count + 1'b1;
    assign down_wrap = (count == '0);
    assign down_val  = down_wrap ? WIDTH'(MAX_COUNT) : count - 1'b1;

    assign dir_val    = (dir == DIR_UP) ? up_val : down_val;
    assign dir_wrap   = (dir == DIR_UP) ? up_wrap : down_wrap;
    assign active_key = (dir == DIR_UP) ? i_Key_Up : i_Key_Down;
    assign other_key  = (dir == DIR_UP) ? i_Key_Down : i_Key_Up;

    repeat_timer #(
        .WIDTH(TW)
    ) u_timer (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_Load      (timer_load),
        .i_Load_Value(timer_load_value),
        .i_Enable    (timer_en),
        .o_Count     (timer_count),
        .o_Zero      (timer_zero)
    );

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state      <= S_IDLE;
            dir        <= DIR_UP;
            count      <= '0;
            key_up_q   <= 1'b0;
            key_down_q <= 1'b0;
            o_Step     <= 1'b0;
            o_Wrap     <= 1'b0;
        end else begin
            state      <= next_state;
            dir        <= next_dir;
            count      <= next_count;
            key_up_q   <= i_Key_Up;
            key_down_q <= i_Key_Down;
            o_Step     <= step_next;
            o_Wrap     <= wrap_next;
        end
    end

    // Within a held state the checks run in order release, chord, timer so
    // that coincident events resolve with that priority.
    always_comb begin
        next_state       = state;
        next_dir         = dir;
        next_count       = count;
        step_next        = 1'b0;
        wrap_next        = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = '0;
        timer_en         = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_Key_Up && i_Key_Down) begin
                    next_count = '0;
                    step_next  = 1'b1;
                    next_state = S_CHORD;
                end else if (rise_up) begin
                    next_count       = up_val;
                    wrap_next        = up_wrap;
                    step_next        = 1'b1;
                    next_dir         = DIR_UP;
                    timer_load       = 1'b1;
                    timer_load_value = TW'(HOLD_CYCLES - 1);
                    next_state       = S_HOLD;
                end else if (rise_down) begin
                    next_count       = down_val;
                    wrap_next        = down_wrap;
                    step_next        = 1'b1;
                    next_dir         = DIR_DOWN;
                    timer_load       = 1'b1;
                    timer_load_value = TW'(HOLD_CYCLES - 1);
                    next_state       = S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (!active_key) begin
                    next_state = S_IDLE;
                end else if (other_key) begin
                    next_count = '0;
                    step_next  = 1'b1;
                    next_state = S_CHORD;
                end else if (timer_zero) begin
                    next_count       = dir_val;
                    wrap_next        = dir_wrap;
                    step_next        = 1'b1;
                    timer_load       = 1'b1;
                    timer_load_value = TW'(REPEAT_CYCLES - 1);
                    next_state       = S_REPEAT;
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_CHORD: begin
                if (!i_Key_Up && !i_Key_Down) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign o_Count     = count;
    assign o_Digit_Hi  = count[WIDTH-1:WIDTH/2];
    assign o_Digit_Lo  = count[WIDTH/2-1:0];
    assign o_Repeating = (state == S_REPEAT);
    assign o_State     = state;

endmodule

// File: tb/tb_key_repeat_counter_ctrl.sv
module tb_key_repeat_counter_ctrl;
    import seg_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       key_up, key_down;
    logic [7:0] count;
    logic [3:0] digit_hi, digit_lo;
    logic       step, wrap, repeating;
    logic [1:0] state;

    logic       k9_up, k9_down;
    logic [7:0] count9;
    logic [3:0] digit_hi9, digit_lo9;
    logic       step9, wrap9, repeating9;
    logic [1:0] state9;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    key_repeat_counter_ctrl #(
        .WIDTH(8), .MAX_COUNT(255), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Key_Up(key_up), .i_Key_Down(key_down),
        .o_Count(count), .o_Digit_Hi(digit_hi), .o_Digit_Lo(digit_lo),
        .o_Step(step), .o_Wrap(wrap), .o_Repeating(repeating), .o_State(state)
    );

    key_repeat_counter_ctrl #(
        .WIDTH(8), .MAX_COUNT(9), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
    ) dut9 (
        .i_Clk(clk), .i_Reset(rst), .i_Key_Up(k9_up), .i_Key_Down(k9_down),
        .o_Count(count9), .o_Digit_Hi(digit_hi9), .o_Digit_Lo(digit_lo9),
        .o_Step(step9), .o_Wrap(wrap9), .o_Repeating(repeating9), .o_State(state9)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // outputs sampled and inputs driven 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        key_up   = 1'b0;
        key_down = 1'b0;
        k9_up    = 1'b0;
        k9_down  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int steps;
        logic [19:0] step_mask, rep_mask;
        int budget;

        // ---- reset state ----
        do_reset();
        check("reset_count", count, 8'h00);
        check("reset_step", step, 1'b0);
        check("reset_wrap", wrap, 1'b0);
        check("reset_rep", repeating, 1'b0);
        check("reset_state", state, S_IDLE);

        // ---- 1: short Up tap ----
        steps  = 0;
        key_up = 1'b1;
        tick();
        check("t1_count_first", count, 8'h01);
        check("t1_step_first", step, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            steps += int'(step);
            check("t1_rep", repeating, 1'b0);
        end
        key_up = 1'b0;
        tick();
        steps += int'(step);
        check("t1_extra_steps", steps, 0);
        check("t1_count", count, 8'h01);
        check("t1_hi", digit_hi, 4'h0);
        check("t1_lo", digit_lo, 4'h1);

        // ---- 2: hold Up 20 clocks ----
        do_reset();
        key_up = 1'b1;
        step_mask = '0;
        rep_mask  = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            step_mask[i] = step;
            rep_mask[i]  = repeating;
        end
        check("t2_step_mask", step_mask, 20'h11101);
        check("t2_rep_mask", rep_mask, 20'hFFF00);
        check("t2_count", count, 8'h04);
        key_up = 1'b0;
        tick();
        check("t2_rep_release", repeating, 1'b0);
        check("t2_state_release", state, S_IDLE);

        // ---- 3: wrap both ways ----
        do_reset();
        key_down = 1'b1;
        tick();
        check("t3_down_count", count, 8'hFF);
        check("t3_down_wrap", wrap, 1'b1);
        check("t3_down_step", step, 1'b1);
        check("t3_down_hi", digit_hi, 4'hF);
        key_down = 1'b0;
        tick();
        check("t3_wrap_clear", wrap, 1'b0);
        key_up = 1'b1;
        tick();
        check("t3_up_count", count, 8'h00);
        check("t3_up_wrap", wrap, 1'b1);
        key_up = 1'b0;
        tick();

        // ---- 4: chord clear out of repeat ----
        do_reset();
        key_down = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("t4_rep_count", count, 8'hFE);
        check("t4_rep_state", state, S_REPEAT);
        key_up = 1'b1;
        tick();
        check("t4_clear_count", count, 8'h00);
        check("t4_clear_step", step, 1'b1);
        check("t4_clear_wrap", wrap, 1'b0);
        check("t4_chord_state", state, S_CHORD);
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            steps += int'(step);
        end
        key_up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            steps += int'(step);
        end
        check("t4_chord_hold_state", state, S_CHORD);
        key_down = 1'b0;
        tick();
        steps += int'(step);
        check("t4_chord_steps", steps, 0);
        check("t4_idle_state", state, S_IDLE);
        key_up = 1'b1;
        tick();
        check("t4_after_tap", count, 8'h01);
        key_up = 1'b0;
        tick();

        // ---- 5: async reset mid-repeat with Up held ----
        do_reset();
        key_up = 1'b1;
        budget = 400;
        while (count != 8'h37 && budget > 0) begin
            tick();
            budget--;
        end
        check("t5_reach_budget", (budget > 0), 1'b1);
        check("t5_rep_before", repeating, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_count", count, 8'h00);
        check("t5_rst_hi", digit_hi, 4'h0);
        check("t5_rst_lo", digit_lo, 4'h0);
        check("t5_rst_step", step, 1'b0);
        check("t5_rst_wrap", wrap, 1'b0);
        check("t5_rst_rep", repeating, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        check("t5_post_count", count, 8'h01);
        check("t5_post_step", step, 1'b1);
        steps = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            steps += int'(step);
        end
        check("t5_hold_steps", steps, 1);
        check("t5_hold_count", count, 8'h02);
        check("t5_hold_rep", repeating, 1'b1);
        key_up = 1'b0;
        tick();

        // ---- 6: MAX_COUNT = 9 instance ----
        do_reset();
        for (int i = 1; i <= 10; i++) exp_q.push_back(8'(i % 10));
        for (int i = 0; i < 10; i++) begin
            logic [7:0] exp_c;
            k9_up = 1'b1;
            tick();
            exp_c = exp_q.pop_front();
            check($sformatf("t6_tap%0d_count", i), count9, exp_c);
            check($sformatf("t6_tap%0d_wrap", i), wrap9, (i == 9) ? 1'b1 : 1'b0);
            k9_up = 1'b0;
            tick();
        end
        k9_down = 1'b1;
        tick();
        check("t6_down_count", count9, 8'h09);
        check("t6_down_wrap", wrap9, 1'b1);
        k9_down = 1'b0;
        tick();
        check("t6_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
